// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_ctrl_pkg
// Description : Shared definitions for the ring-oscillator PUF measurement
//               controller: FSM state encoding, field widths and the
//               oscillator-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_ctrl_pkg;

    localparam int c_BIT_IDX_W = 3;   // indexes up to 8 response bits
    localparam int c_OSC_SEL_W = 5;   // 32 oscillator pairs per bank
    localparam int c_RESP_W    = 8;   // width of response / resp_mask
    localparam int c_CNT_W     = 8;   // width of each edge counter

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_t;

    // Oscillator pair for a given response bit; wraps modulo 32.
    function automatic logic [c_OSC_SEL_W-1:0] f_osc_sel(
        input logic [c_OSC_SEL_W-1:0] chal,
        input logic [c_BIT_IDX_W-1:0] idx
    );
        return chal + {{(c_OSC_SEL_W - c_BIT_IDX_W){1'b0}}, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_window_timer.sv
`default_nettype none
// ============================================================================
// Module      : puf_window_timer
// Description : Loadable down-counter timing the oscillator window and the
//               settle gap. A load of value V produces o_expire in the
//               (V+1)-th cycle after the load edge, i.e. an interval of V+1
//               cycles. A load in the expiring cycle chains a new interval
//               with no gap.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               i_load     - load i_load_val and start counting
//               i_load_val - interval length minus one
//               o_expire   - high in the final cycle of the interval
// Revision    : 1.0 - initial release
// ============================================================================
module puf_window_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;
    logic             r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_expire = r_active && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/puf_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puf_meas_ctrl
// Description : Ring-oscillator PUF measurement sequencer. For each response
//               bit it clears the edge counters, enables both oscillator
//               banks for WINDOW_CYCLES, waits SETTLE_CYCLES, then compares
//               the two counts (response bit = count_a > count_b).
// Ports       : clk        - rising-edge clock
//               rst_n      - synchronous reset, ACTIVE HIGH despite the name
//               start      - begin a measurement (honoured only in IDLE)
//               challenge  - base oscillator select, latched on start
//               count_a/_b - edge counts from the two banks
//               osc_en     - oscillator bank enable
//               cnt_clr    - edge counter clear
//               osc_sel    - oscillator select (challenge + bit index)
//               busy       - measurement in progress (start .. DONE)
//               resp_valid - one-cycle pulse, response/resp_mask valid
//               response   - response bits, bits >= N_BITS are zero
//               resp_mask  - unreliable-bit flags
// Config      : PUF_RELIABILITY_MASK_EN - when defined, resp_mask flags bits
//               whose count difference is below THRESH or whose counters
//               saturated; otherwise resp_mask is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_meas_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS        = 8,   // 1..8
    parameter int WINDOW_CYCLES = 64,  // 2..255
    parameter int SETTLE_CYCLES = 2,   // 1..15
    parameter int THRESH        = 4    // 0..511
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [c_OSC_SEL_W-1:0] challenge,
    input  logic [c_CNT_W-1:0]     count_a,
    input  logic [c_CNT_W-1:0]     count_b,
    output logic                   osc_en,
    output logic                   cnt_clr,
    output logic [c_OSC_SEL_W-1:0] osc_sel,
    output logic                   busy,
    output logic                   resp_valid,
    output logic [c_RESP_W-1:0]    response,
    output logic [c_RESP_W-1:0]    resp_mask
);

    localparam logic [c_BIT_IDX_W-1:0] c_LAST_BIT    = c_BIT_IDX_W'(N_BITS - 1);
    localparam logic [7:0]             c_RUN_LOAD    = 8'(WINDOW_CYCLES - 1);
    localparam logic [7:0]             c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    puf_state_t               r_state;
    logic [c_BIT_IDX_W-1:0]   r_bit_idx;
    logic [c_OSC_SEL_W-1:0]   r_challenge;
    logic                     r_osc_en;
    logic                     r_cnt_clr;
    logic [c_OSC_SEL_W-1:0]   r_osc_sel;
    logic                     r_busy;
    logic                     r_resp_valid;
    logic [c_RESP_W-1:0]      r_response;

    logic                     w_tmr_load;
    logic [7:0]               w_tmr_val;
    logic                     w_tmr_expire;
    logic [c_BIT_IDX_W-1:0]   w_next_idx;
    logic                     w_bit_val;

    // The window timer is loaded in CLEAR (for RUN) and again in the last RUN
    // cycle (for SETTLE), so both intervals start on the state change itself.
    assign w_tmr_load = (r_state == ST_CLEAR) || ((r_state == ST_RUN) && w_tmr_expire);
    assign w_tmr_val  = (r_state == ST_CLEAR) ? c_RUN_LOAD : c_SETTLE_LOAD;
    assign w_next_idx = r_bit_idx + c_BIT_IDX_W'(1);
    assign w_bit_val  = (count_a > count_b);

    puf_window_timer #(
        .WIDTH(8)
    ) u_timer (
        .clk       (clk),
        .rst       (rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_expire  (w_tmr_expire)
    );

`ifdef PUF_RELIABILITY_MASK_EN
    localparam logic [8:0] c_THRESH = 9'(THRESH);

    logic [8:0]          w_diff;
    logic                w_unreliable;
    logic [c_RESP_W-1:0] r_resp_mask;

    // 9-bit magnitude so 255 vs 0 yields 255 instead of wrapping.
    always_comb begin
        w_diff = 9'd0;
        if (count_a > count_b) begin
            w_diff = {1'b0, count_a} - {1'b0, count_b};
        end else begin
            w_diff = {1'b0, count_b} - {1'b0, count_a};
        end
    end

    assign w_unreliable = (w_diff < c_THRESH) || (count_a == 8'hFF) || (count_b == 8'hFF);
    assign resp_mask    = r_resp_mask;
`else
    // THRESH only matters when the mask is compiled in; both arms tie off.
    if (THRESH > 0) begin : g_mask_off
        assign resp_mask = '0;
    end else begin : g_mask_off_zero_thresh
        assign resp_mask = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_challenge  <= '0;
            r_osc_en     <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_osc_sel    <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_response   <= '0;
`ifdef PUF_RELIABILITY_MASK_EN
            r_resp_mask  <= '0;
`endif
        end else begin
            r_cnt_clr    <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_challenge <= challenge;
                        r_bit_idx   <= '0;
                        r_osc_sel   <= challenge;
                        r_cnt_clr   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_response  <= '0;
`ifdef PUF_RELIABILITY_MASK_EN
                        r_resp_mask <= '0;
`endif
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_osc_en <= 1'b1;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_tmr_expire) begin
                        r_osc_en <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_expire) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_response[r_bit_idx] <= w_bit_val;
`ifdef PUF_RELIABILITY_MASK_EN
                    r_resp_mask[r_bit_idx] <= w_unreliable;
`endif
                    if (r_bit_idx == c_LAST_BIT) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_bit_idx <= w_next_idx;
                        r_osc_sel <= f_osc_sel(r_challenge, w_next_idx);
                        r_cnt_clr <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_osc_en <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign osc_en     = r_osc_en;
    assign cnt_clr    = r_cnt_clr;
    assign osc_sel    = r_osc_sel;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign response   = r_response;

endmodule
`default_nettype wire

// File: tb/tb_puf_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_meas_ctrl
// Description : Self-checking bench for puf_meas_ctrl. The oscillator banks
//               are modelled as per-oscillator count tables addressed by
//               osc_sel; expected responses come from those tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_meas_ctrl;

    localparam int N_BITS  = 8;
    localparam int WINDOW  = 64;
    localparam int SETTLE  = 2;
    localparam int THRESH  = 4;
    localparam int LAT     = N_BITS * (WINDOW + SETTLE + 2);
`ifdef PUF_RELIABILITY_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] challenge = '0;
    logic [7:0] count_a, count_b;
    logic       osc_en, cnt_clr, busy, resp_valid;
    logic [4:0] osc_sel;
    logic [7:0] response, resp_mask;

    logic [7:0] ca [32];
    logic [7:0] cb [32];

    assign count_a = ca[osc_sel];
    assign count_b = cb[osc_sel];

    always #5 clk = ~clk;

    puf_meas_ctrl #(
        .N_BITS(N_BITS), .WINDOW_CYCLES(WINDOW), .SETTLE_CYCLES(SETTLE), .THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .count_a(count_a), .count_b(count_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
        .osc_sel(osc_sel), .busy(busy), .resp_valid(resp_valid),
        .response(response), .resp_mask(resp_mask)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: got no DUT event within the cycle budget, expected one", name);
    endtask

    // Reference: bit i reads oscillator (chal+i) mod 32 from the bank tables.
    function automatic void model(input logic [4:0] chal, output logic [7:0] r, output logic [7:0] m);
        int osc, a, b, d;
        r = '0;
        m = '0;
        for (int i = 0; i < N_BITS; i++) begin
            osc = (int'(chal) + i) % 32;
            a = int'(ca[osc]);
            b = int'(cb[osc]);
            d = a - b;
            if (d < 0) d = -d;
            r[i] = (a > b);
            m[i] = MASK_EN && ((d < THRESH) || (a == 255) || (b == 255));
        end
    endfunction

    task automatic randomize_banks();
        logic [7:0] v, w;
        for (int k = 0; k < 32; k++) begin
            v = 8'($urandom_range(0, 255));
            w = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 4))
                0: w = v;
                1: v = 8'hFF;
                2: w = v ^ 8'($urandom_range(0, 7));
                default: ;
            endcase
            ca[k] = v;
            cb[k] = w;
        end
    endtask

    // Runs one measurement from IDLE; checks timing/osc_sel on the way.
    task automatic measure(input logic [4:0] chal, input string tag,
                           output logic [7:0] r, output logic [7:0] m);
        int cyc, clr_n, run_len, n_runs;
        bit sel_ok, stable, runs_ok, got;
        logic [4:0] prev_sel;
        r = '0; m = '0; cyc = 0; clr_n = 0; run_len = 0; n_runs = 0;
        sel_ok = 1; stable = 1; runs_ok = 1; got = 0; prev_sel = '0;
        challenge = chal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        challenge = ~chal;
        while (!got && cyc < 3000) begin
            if (cnt_clr) begin
                if (osc_sel !== 5'((int'(chal) + clr_n) % 32)) sel_ok = 0;
                clr_n++;
            end else if (!resp_valid && osc_sel !== prev_sel) begin
                stable = 0;
            end
            prev_sel = osc_sel;
            if (osc_en) run_len++;
            else if (run_len != 0) begin
                n_runs++;
                if (run_len != WINDOW) runs_ok = 0;
                run_len = 0;
            end
            if (resp_valid) begin
                got = 1;
                r = response;
                m = resp_mask;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            timeout({tag, " resp_valid"});
        end else begin
            chk({tag, " latency"}, cyc, LAT);
            chk({tag, " osc_sel steps"}, sel_ok, 1);
            chk({tag, " cnt_clr count"}, clr_n, N_BITS);
            chk({tag, " osc_sel stable"}, stable, 1);
            chk({tag, " osc_en windows"}, n_runs, N_BITS);
            chk({tag, " osc_en length"}, runs_ok, 1);
            chk({tag, " busy in DONE"}, busy, 1);
            @(negedge clk);
            chk({tag, " resp_valid pulse width"}, resp_valid, 0);
            chk({tag, " busy after DONE"}, busy, 0);
        end
    endtask

    typedef struct {
        logic [4:0] chal;
        logic [7:0] ae, be, ao, bo;   // counts on even / odd bits
        logic [7:0] exp_r, exp_m;     // exp_m applies with the mask built in
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [7:0] r, m, er, em, r1, m1, r2, m2, e1, em1, e2, em2;
        logic [4:0] chal;
        int cyc, clr_n, idle_n, pulses, t1, gap;
        bit seen;

        tbl[0] = '{5'd30, 8'd120, 8'd80,  8'd80,  8'd120, 8'h55, 8'h00};
        tbl[1] = '{5'd0,  8'd100, 8'd100, 8'd100, 8'd100, 8'h00, 8'hFF};
        tbl[2] = '{5'd7,  8'd255, 8'd10,  8'd50,  8'd45,  8'hFF, 8'h55};
        tbl[3] = '{5'd12, 8'd50,  8'd47,  8'd0,   8'd255, 8'h55, 8'hFF};
        tbl[4] = '{5'd31, 8'd10,  8'd200, 8'd201, 8'd200, 8'hAA, 8'hAA};
        tbl[5] = '{5'd3,  8'd54,  8'd50,  8'd50,  8'd54,  8'h55, 8'h00};

        for (int k = 0; k < 32; k++) begin
            ca[k] = '0;
            cb[k] = '0;
        end

        // Reset state
        rst_n = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        chk("reset osc_en", osc_en, 0);
        chk("reset cnt_clr", cnt_clr, 0);
        chk("reset osc_sel", osc_sel, 0);
        chk("reset busy", busy, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset response", response, 0);
        chk("reset resp_mask", resp_mask, 0);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 32; k++) begin
                ca[k] = 8'd1;
                cb[k] = 8'd2;
            end
            for (int i = 0; i < N_BITS; i++) begin
                ca[(int'(tbl[t].chal) + i) % 32] = (i % 2 == 0) ? tbl[t].ae : tbl[t].ao;
                cb[(int'(tbl[t].chal) + i) % 32] = (i % 2 == 0) ? tbl[t].be : tbl[t].bo;
            end
            measure(tbl[t].chal, $sformatf("tbl%0d", t), r, m);
            chk($sformatf("tbl%0d response", t), r, tbl[t].exp_r);
            chk($sformatf("tbl%0d resp_mask", t), m, MASK_EN ? tbl[t].exp_m : 8'h00);
        end

        // Randomized against the reference model
        for (int n = 0; n < 6; n++) begin
            randomize_banks();
            chal = 5'($urandom_range(0, 31));
            model(chal, er, em);
            measure(chal, $sformatf("rnd%0d", n), r, m);
            chk($sformatf("rnd%0d response", n), r, er);
            chk($sformatf("rnd%0d resp_mask", n), m, em);
        end

        // Reset in the middle of RUN on bit 3
        for (int k = 0; k < 32; k++) begin
            ca[k] = 8'd200;
            cb[k] = 8'd100;
        end
        challenge = 5'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        clr_n = 0;
        while (cyc < 2000) begin
            if (cnt_clr) clr_n++;
            if (clr_n == 4) break;
            @(negedge clk);
            cyc++;
        end
        if (clr_n != 4) begin
            timeout("abort reach bit3");
        end else begin
            repeat (10) @(negedge clk);
            chk("abort pre osc_en", osc_en, 1);
            chk("abort pre response", response, 8'h07);
            rst_n = 1'b1;
            @(negedge clk);
            rst_n = 1'b0;
            chk("abort osc_en", osc_en, 0);
            chk("abort busy", busy, 0);
            chk("abort cnt_clr", cnt_clr, 0);
            chk("abort response", response, 0);
            seen = 0;
            for (int i = 0; i < 700; i++) begin
                if (resp_valid || busy) seen = 1;
                @(negedge clk);
            end
            chk("abort no resp_valid", seen, 0);
        end

        // start held high: back-to-back measurements, challenge change ignored
        randomize_banks();
        model(5'd17, e1, em1);
        model(5'd2, e2, em2);
        challenge = 5'd17;
        start = 1'b1;
        cyc = 0; pulses = 0; idle_n = 0; clr_n = 0; t1 = 0; gap = 0;
        r1 = '0; m1 = '0; r2 = '0; m2 = '0;
        while (pulses < 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) challenge = 5'd2;
            if (pulses == 1) begin
                if (!busy) idle_n++;
                if (cnt_clr) clr_n++;
            end
            if (resp_valid) begin
                if (pulses == 0) begin
                    r1 = response; m1 = resp_mask; t1 = cyc;
                end else begin
                    r2 = response; m2 = resp_mask; gap = cyc - t1;
                    start = 1'b0;
                end
                pulses++;
            end
        end
        start = 1'b0;
        if (pulses < 2) begin
            timeout("held start two pulses");
        end else begin
            chk("held meas1 response", r1, e1);
            chk("held meas1 resp_mask", m1, em1);
            chk("held meas2 response", r2, e2);
            chk("held meas2 resp_mask", m2, em2);
            chk("held pulse spacing", gap, LAT + 2);
            chk("held idle cycles", idle_n, 1);
            chk("held cnt_clr count", clr_n, N_BITS);
            repeat (3) @(negedge clk);
            chk("held no third meas", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
